// File: rtl/serial_add_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sequencer_pkg
// Purpose  : Shared definitions for the nibble-serial adder sequencer:
//            slice width, FSM state encoding and a counter-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_sequencer_pkg;

   // Width of the single adder slice that is reused every cycle.
   localparam int SLICE_W = 4;

   // 2'd3 is never entered; the FSM treats it exactly like IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Slice counter width: max(1, clog2(nslice)).
   function automatic int calc_cnt_w(input int nslice);
      return (nslice > 1) ? $clog2(nslice) : 1;
   endfunction

endpackage : serial_add_sequencer_pkg
`default_nettype wire

// File: rtl/serial_add_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sequencer_if
// Purpose  : Operand/result handshake bundle for serial_add_sequencer.
// Signals  : in_valid/in_ready/in_a/in_b/in_cin  - operand channel
//            out_valid/out_ready/sum/cout          - result channel
//            busy                                  - sequencer status
// Modports : slave  - the sequencer side
//            master - the producer/consumer side
// Revision : 1.0 - initial release
// ============================================================================
interface serial_add_sequencer_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport slave (
      input  in_valid, in_a, in_b, in_cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );

   modport master (
      output in_valid, in_a, in_b, in_cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );
endinterface : serial_add_sequencer_if
`default_nettype wire

// File: rtl/serial_add_sequencer_adder_slice_4.sv
`default_nettype none
// ============================================================================
// Module   : full_adder / adder_slice_4
// Purpose  : One-bit full adder cell and the 4-bit ripple slice built from
//            four of them. The slice is the only arithmetic in the sequencer.
// Ports    : a_i, b_i   - slice operands
//            cin_i      - carry into bit 0
//            sum_o      - slice sum
//            cout_o     - carry out of the top bit
// Revision : 1.0 - initial release
// ============================================================================
module full_adder (
   input  wire logic a_i,
   input  wire logic b_i,
   input  wire logic cin_i,
   output logic      sum_o,
   output logic      cout_o
);
   assign sum_o  = a_i ^ b_i ^ cin_i;
   assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule : full_adder

module adder_slice_4
   import serial_add_sequencer_pkg::*;
(
   input  wire logic [SLICE_W-1:0] a_i,
   input  wire logic [SLICE_W-1:0] b_i,
   input  wire logic               cin_i,
   output logic      [SLICE_W-1:0] sum_o,
   output logic                    cout_o
);
   // w_carry[i] is the carry into bit i; w_carry[SLICE_W] leaves the slice.
   logic [SLICE_W:0] w_carry;

   assign w_carry[0] = cin_i;

   for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
      full_adder u_fa (
         .a_i    (a_i[i]),
         .b_i    (b_i[i]),
         .cin_i  (w_carry[i]),
         .sum_o  (sum_o[i]),
         .cout_o (w_carry[i+1])
      );
   end

   assign cout_o = w_carry[SLICE_W];
endmodule : adder_slice_4
`default_nettype wire

// File: rtl/serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_sequencer
// Purpose  : Computes WIDTH-bit A+B+cin by running one 4-bit adder slice over
//            the operands, one nibble per cycle, LSB first. The carry is held
//            in a register between slices.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            bus    - operand/result handshake (serial_add_sequencer_if.slave)
//                     in_valid/in_ready/in_a/in_b/in_cin in,
//                     out_valid/out_ready/sum/cout out, busy status
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_sequencer
   import serial_add_sequencer_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   serial_add_sequencer_if.slave bus
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int CNT_W  = calc_cnt_w(NSLICE);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

   // ---------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------
   if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
      $error("serial_add_sequencer: WIDTH must be a multiple of 4 and >= 4");
   end

   if ($bits(bus.sum) != WIDTH) begin : g_bad_if_width
      $error("serial_add_sequencer: interface WIDTH does not match module WIDTH");
   end

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic [WIDTH-1:0] sum_q,   sum_d;
   logic             cout_q,  cout_d;

   // ---------------------------------------------------------------------
   // Single reused adder slice, fed from the operand LSB nibbles
   // ---------------------------------------------------------------------
   logic [SLICE_W-1:0] w_slice_sum;
   logic               w_slice_cout;

   adder_slice_4 u_slice (
      .a_i    (a_q[SLICE_W-1:0]),
      .b_i    (b_q[SLICE_W-1:0]),
      .cin_i  (carry_q),
      .sum_o  (w_slice_sum),
      .cout_o (w_slice_cout)
   );

   // Shifted register values for one RUN step. A single-slice build has
   // nothing to shift, so it gets its own branch to avoid empty slices.
   logic [WIDTH-1:0] w_a_shift;
   logic [WIDTH-1:0] w_b_shift;
   logic [WIDTH-1:0] w_sum_shift;

   if (NSLICE == 1) begin : g_single_slice
      assign w_a_shift   = '0;
      assign w_b_shift   = '0;
      assign w_sum_shift = w_slice_sum;
   end else begin : g_multi_slice
      // Operands shift right; each new result nibble enters at the top so
      // that after NSLICE steps the first nibble has reached bit 0.
      assign w_a_shift   = {{SLICE_W{1'b0}}, a_q[WIDTH-1:SLICE_W]};
      assign w_b_shift   = {{SLICE_W{1'b0}}, b_q[WIDTH-1:SLICE_W]};
      assign w_sum_shift = {w_slice_sum, sum_q[WIDTH-1:SLICE_W]};
   end

   // ---------------------------------------------------------------------
   // Sequential state
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      case (state_q)
         ST_RUN: begin
            a_d     = w_a_shift;
            b_d     = w_b_shift;
            sum_d   = w_sum_shift;
            carry_d = w_slice_cout;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               // Final slice: the carry out becomes the visible cout.
               cout_d  = w_slice_cout;
               cnt_d   = '0;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            // sum/cout are left untouched so they persist into IDLE.
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            // IDLE, and the unused encoding which behaves as IDLE.
            state_d = ST_IDLE;
            if (bus.in_valid) begin
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               carry_d = bus.in_cin;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs: decoded from registers only, so no input-to-output path.
   // ---------------------------------------------------------------------
   assign bus.in_ready  = (state_q != ST_RUN) && (state_q != ST_DONE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;

endmodule : serial_add_sequencer
`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_sequencer
// Purpose  : Self-checking bench for serial_add_sequencer. A transaction-level
//            model predicts handshake timing and results from plain integer
//            arithmetic; directed vectors add literal expectations.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_sequencer;

   localparam int W  = 16;
   localparam int NS = W / 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   serial_add_sequencer_if #(.WIDTH(W)) bus ();
   serial_add_sequencer_if #(.WIDTH(4)) bus4 ();

   serial_add_sequencer #(.WIDTH(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   serial_add_sequencer #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Model: an op occupies NS cycles of work, then waits for the consumer.
   // m_left counts remaining work cycles; m_done means a result is offered.
   // ------------------------------------------------------------------
   int          m_left    = 0;
   bit          m_done    = 1'b0;
   logic [16:0] m_pend    = '0;
   logic [16:0] m_res     = '0;
   int          m_retired = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_res  <= '0;
      end else if (m_left == 0 && !m_done) begin
         if (bus.in_valid) begin
            m_left <= NS;
            m_pend <= {1'b0, bus.in_a} + {1'b0, bus.in_b} + 17'(bus.in_cin);
         end
      end else if (m_left > 0) begin
         if (m_left == 1) begin
            m_done <= 1'b1;
            m_res  <= m_pend;
         end
         m_left <= m_left - 1;
      end else if (bus.out_ready) begin
         m_done    <= 1'b0;
         m_retired <= m_retired + 1;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("in_ready",  32'(bus.in_ready),  32'(m_left == 0 && !m_done));
      check("out_valid", 32'(bus.out_valid), 32'(m_done));
      check("busy",      32'(bus.busy),      32'(m_left != 0 || m_done));
      if (m_left == 0) begin
         check("sum",  32'(bus.sum),  32'(m_res[15:0]));
         check("cout", 32'(bus.cout), 32'(m_res[16]));
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
      int t;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = c;
      for (t = 0; t < 100; t++) begin
         @(negedge clk);
         if (bus.in_ready) break;
      end
      if (t == 100) check("send_timeout", 32'(1), 32'(0));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_result(input string name, input logic [15:0] es, input logic ec);
      int t;
      for (t = 0; t < 100; t++) begin
         @(negedge clk);
         if (bus.out_valid) break;
      end
      if (t == 100) check({name, "_timeout"}, 32'(1), 32'(0));
      check({name, "_sum"},  32'(bus.sum),  32'(es));
      check({name, "_cout"}, 32'(bus.cout), 32'(ec));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int t;
      for (t = 0; t < 200; t++) begin
         @(negedge clk);
         if (m_left == 0 && !m_done) break;
      end
      if (t == 200) check("idle_timeout", 32'(1), 32'(0));
      @(posedge clk);
      #1;
   endtask

   int  lat;
   int  low_cnt;
   int  retired0;
   bit  drv_done;
   logic [15:0] cap_sum;
   logic        cap_cout;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_cin    = 1'b0;
      bus.out_ready = 1'b0;
      bus4.in_valid  = 1'b0;
      bus4.in_a      = '0;
      bus4.in_b      = '0;
      bus4.in_cin    = 1'b0;
      bus4.out_ready = 1'b0;

      // Reset state
      #2;
      check("rst_in_ready",  32'(bus.in_ready),  32'(1));
      check("rst_out_valid", 32'(bus.out_valid), 32'(0));
      check("rst_sum",       32'(bus.sum),       32'(0));
      check("rst_cout",      32'(bus.cout),      32'(0));
      check("rst_busy",      32'(bus.busy),      32'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: FFFF + 0001 + 0 -> 0000 carry 1, valid 4 edges after accept
      bus.out_ready = 1'b1;
      send(16'hFFFF, 16'h0001, 1'b0);
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
         if (bus.out_valid) break;
      end
      check("t1_latency", 32'(lat), 32'(4));
      check("t1_sum",  32'(bus.sum),  32'h0000);
      check("t1_cout", 32'(bus.cout), 32'(1));
      wait_idle();

      // 2: 1234 + 4321 + 1 -> 5556; in_ready low across RUN (4) + DONE (1)
      send(16'h1234, 16'h4321, 1'b1);
      low_cnt  = 0;
      cap_sum  = '0;
      cap_cout = 1'b1;
      while (low_cnt < 50) begin
         @(negedge clk);
         if (bus.in_ready) break;
         if (bus.out_valid) begin
            cap_sum  = bus.sum;
            cap_cout = bus.cout;
         end
         low_cnt++;
      end
      check("t2_ready_low", 32'(low_cnt), 32'(5));
      check("t2_sum",  32'(cap_sum),  32'h5556);
      check("t2_cout", 32'(cap_cout), 32'(0));
      wait_idle();

      // 3: backpressure; second op offered during DONE, taken after retire
      bus.out_ready = 1'b0;
      send(16'h0F0F, 16'h00F1, 1'b0);
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (bus.out_valid) break;
      end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 16'h8000;
            bus.in_b     = 16'h8000;
            bus.in_cin   = 1'b1;
         end
         check("t3_hold_valid", 32'(bus.out_valid), 32'(1));
         check("t3_hold_sum",   32'(bus.sum),       32'h1000);
         check("t3_hold_cout",  32'(bus.cout),      32'(0));
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t3_retire_valid", 32'(bus.out_valid), 32'(0));
      check("t3_retire_ready", 32'(bus.in_ready),  32'(1));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("t3_accept_busy", 32'(bus.busy), 32'(1));
      wait_result("t3_op2", 16'h0001, 1'b1);
      wait_idle();

      // 4: reset during the second RUN cycle, then 1 + 1
      send(16'h1234, 16'h1111, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t4_in_ready",  32'(bus.in_ready),  32'(1));
      check("t4_out_valid", 32'(bus.out_valid), 32'(0));
      check("t4_sum",       32'(bus.sum),       32'(0));
      check("t4_cout",      32'(bus.cout),      32'(0));
      check("t4_busy",      32'(bus.busy),      32'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(16'h0001, 16'h0001, 1'b0);
      wait_result("t4_op", 16'h0002, 1'b0);
      wait_idle();

      // 5: WIDTH=4 instance, F + F + 1 -> F carry 1, one edge of latency
      bus4.out_ready = 1'b1;
      bus4.in_valid  = 1'b1;
      bus4.in_a      = 4'hF;
      bus4.in_b      = 4'hF;
      bus4.in_cin    = 1'b1;
      check("t5_ready", 32'(bus4.in_ready), 32'(1));
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
      check("t5_run_valid", 32'(bus4.out_valid), 32'(0));
      check("t5_run_busy",  32'(bus4.busy),      32'(1));
      @(posedge clk);
      #1;
      check("t5_valid", 32'(bus4.out_valid), 32'(1));
      check("t5_sum",   32'(bus4.sum),       32'hF);
      check("t5_cout",  32'(bus4.cout),      32'(1));
      @(posedge clk);
      #1;
      check("t5_retired", 32'(bus4.out_valid), 32'(0));
      check("t5_idle",    32'(bus4.in_ready),  32'(1));

      // 6: 1000 random ops with random producer gaps and consumer stalls
      retired0 = m_retired;
      drv_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               repeat ($urandom_range(0, 3)) begin
                  @(posedge clk);
                  #1;
               end
               send(16'($urandom), 16'($urandom), 1'($urandom));
            end
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(posedge clk);
               #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = 1'b1;
         end
      join
      wait_idle();
      check("t6_retired", 32'(m_retired - retired0), 32'(1000));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_serial_add_sequencer
`default_nettype wire
